// File: rtl/cla_pkg.sv
// Shared constants, the per-stage control bundle and the group-count helper
// used by the pipelined carry-look-ahead adder.
package cla_pkg;

    localparam int CLA_GRP_W = 4;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int calcNgrp(input int width);
        return width / CLA_GRP_W;
    endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-look-ahead group with group propagate/generate.
module cla4_group (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co,
    output logic       p,
    output logic       g
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = a4 ^ b4;
    assign w_g = a4 & b4;

    // Every internal carry is a flat sum of products of ci, so no ripple path.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);

    assign p  = &w_p;
    assign g  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign co = g | (p & ci);
    assign s4 = w_p ^ w_c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor resolving one 4-bit group per stage.
// Define CLA_FLAGS_EN to add registered zero/neg result flags.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CLA_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int NGRP = calcNgrp(WIDTH);

    if ((WIDTH < CLA_GRP_W) || ((WIDTH % CLA_GRP_W) != 0)) begin : gen_width_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_b_eff  = sub ? ~b : b;

    // Operand skew: each stage drops the nibble it just handed to its group.
    for (genvar k = 0; k < NGRP - 1; k++) begin : gen_skew
        localparam int R = WIDTH - CLA_GRP_W * (k + 1);
        logic [R-1:0] r_a;
        logic [R-1:0] r_b;
        logic [R-1:0] w_a_in;
        logic [R-1:0] w_b_in;

        if (k == 0) begin : gen_src_port
            assign w_a_in = a[WIDTH-1:CLA_GRP_W];
            assign w_b_in = w_b_eff[WIDTH-1:CLA_GRP_W];
        end else begin : gen_src_prev
            assign w_a_in = gen_skew[k-1].r_a[R+CLA_GRP_W-1:CLA_GRP_W];
            assign w_b_in = gen_skew[k-1].r_b[R+CLA_GRP_W-1:CLA_GRP_W];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a <= '0;
                r_b <= '0;
            end else if (w_en) begin
                r_a <= w_a_in;
                r_b <= w_b_in;
            end
        end
    end

    // Sum deskew: each stage carries the nibbles already resolved, so all exit aligned.
    for (genvar k = 0; k < NGRP; k++) begin : gen_stage
        localparam int SW = CLA_GRP_W * (k + 1);
        logic [3:0]    w_a4;
        logic [3:0]    w_b4;
        logic [3:0]    w_s4;
        logic          w_ci;
        logic          w_co;
        logic          w_vin;
        logic [1:0]    w_unused_pg;
        logic [SW-1:0] w_sum_next;
        logic [SW-1:0] r_sum;
        stage_ctl_t    r_ctl;

        if (k == 0) begin : gen_first
            assign w_a4       = a[3:0];
            assign w_b4       = w_b_eff[3:0];
            assign w_ci       = sub | cin;
            assign w_vin      = in_valid;
            assign w_sum_next = w_s4;
        end else begin : gen_next
            assign w_a4       = gen_skew[k-1].r_a[3:0];
            assign w_b4       = gen_skew[k-1].r_b[3:0];
            assign w_ci       = gen_stage[k-1].r_ctl.carry;
            assign w_vin      = gen_stage[k-1].r_ctl.valid;
            assign w_sum_next = {w_s4, gen_stage[k-1].r_sum};
        end

        cla4_group u_group (
            .a4 (w_a4),
            .b4 (w_b4),
            .ci (w_ci),
            .s4 (w_s4),
            .co (w_co),
            .p  (w_unused_pg[1]),
            .g  (w_unused_pg[0])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ctl <= '0;
                r_sum <= '0;
            end else if (w_en) begin
                r_ctl.valid <= w_vin;
                r_ctl.carry <= w_co;
                r_sum       <= w_sum_next;
            end
        end
    end

    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= (gen_stage[NGRP-1].w_a4[3] == gen_stage[NGRP-1].w_b4[3])
                  && (gen_stage[NGRP-1].w_s4[3] != gen_stage[NGRP-1].w_a4[3]);
        end
    end

    assign out_valid = gen_stage[NGRP-1].r_ctl.valid;
    assign cout      = gen_stage[NGRP-1].r_ctl.carry;
    assign sum       = gen_stage[NGRP-1].r_sum;
    assign ovf       = r_ovf;

`ifdef CLA_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_en) begin
            r_zero <= (gen_stage[NGRP-1].w_sum_next == '0);
            r_neg  <= gen_stage[NGRP-1].w_s4[3];
        end
    end

    assign zero = r_zero;
    assign neg  = r_neg;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed WIDTH=16 steps and a
// randomized WIDTH=32 sweep against an arithmetic reference model.
module tb_pipelined_cla_adder;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        inValid16, inReady16, outValid16, outReady16, cin16, sub16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        inValid32, inReady32, outValid32, outReady32, cin32, sub32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;
`ifdef CLA_FLAGS_EN
    logic        zero16, neg16, zero32, neg32;
`endif

    int checks = 0;
    int passes = 0;
    int outCount16 = 0;
    int outCount32 = 0;
    int acceptCount32 = 0;
    res_t q16[$];
    res_t q32[$];

    pipelined_cla_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid16),
        .in_ready  (inReady16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .sub       (sub16),
        .out_valid (outValid16),
        .out_ready (outReady16),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16)
`ifdef CLA_FLAGS_EN
        ,
        .zero      (zero16),
        .neg       (neg16)
`endif
    );

    pipelined_cla_adder #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid32),
        .in_ready  (inReady32),
        .a         (a32),
        .b         (b32),
        .cin       (cin32),
        .sub       (sub32),
        .out_valid (outValid32),
        .out_ready (outReady32),
        .sum       (sum32),
        .cout      (cout32),
        .ovf       (ovf32)
`ifdef CLA_FLAGS_EN
        ,
        .zero      (zero32),
        .neg       (neg32)
`endif
    );

    // Plain integer arithmetic: unsigned result for sum/cout, signed range test for ovf.
    function automatic res_t refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic sub);
        longint modulus, half, full, sa, sb, r;
        res_t   res;
        modulus = longint'(1) << w;
        half    = modulus >> 1;
        if (sub) full = longint'(a) + modulus - longint'(b);
        else     full = longint'(a) + longint'(b) + longint'(cin);
        res.sum  = 32'(full % modulus);
        res.cout = (full >= modulus);
        sa = (longint'(a) >= half) ? longint'(a) - modulus : longint'(a);
        sb = (longint'(b) >= half) ? longint'(b) - modulus : longint'(b);
        r  = sub ? (sa - sb) : (sa + sb + longint'(cin));
        res.ovf = (r >= half) || (r < -half);
        return res;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboards: retire before record so a same-cycle accept and drain stay ordered.
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            q16.delete();
        end else begin
            if (outValid16 && outReady16) begin
                outCount16++;
                checkOutput("pending16", (q16.size() != 0), 1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    checkOutput("sum16", sum16, e.sum[15:0]);
                    checkOutput("cout16", cout16, e.cout);
                    checkOutput("ovf16", ovf16, e.ovf);
`ifdef CLA_FLAGS_EN
                    checkOutput("zero16", zero16, (e.sum[15:0] == 16'h0));
                    checkOutput("neg16", neg16, e.sum[15]);
`endif
                end
            end
            if (inValid16 && inReady16)
                q16.push_back(refModel(16, {16'h0, a16}, {16'h0, b16}, cin16, sub16));
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            q32.delete();
        end else begin
            if (outValid32 && outReady32) begin
                outCount32++;
                checkOutput("pending32", (q32.size() != 0), 1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    checkOutput("sum32", sum32, e.sum);
                    checkOutput("cout32", cout32, e.cout);
                    checkOutput("ovf32", ovf32, e.ovf);
`ifdef CLA_FLAGS_EN
                    checkOutput("zero32", zero32, (e.sum == 32'h0));
                    checkOutput("neg32", neg32, e.sum[31]);
`endif
                end
            end
            if (inValid32 && inReady32) begin
                acceptCount32++;
                q32.push_back(refModel(32, a32, b32, cin32, sub32));
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
        inValid16 = 1'b1;
        a16 = a;
        b16 = b;
        cin16 = cin;
        sub16 = sub;
    endtask

    task automatic runOne(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [15:0] expSum, input logic expCout,
                          input logic expOvf, input string tag);
        int lat;
        applyStimulus(a, b, cin, sub);
        checkOutput({tag, " in_ready"}, inReady16, 1);
        @(posedge clk);
        #1;
        inValid16 = 1'b0;
        lat = 1;
        while (!outValid16 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " latency"}, lat, 4);
        checkOutput({tag, " sum"}, sum16, expSum);
        checkOutput({tag, " cout"}, cout16, expCout);
        checkOutput({tag, " ovf"}, ovf16, expOvf);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((q16.size() != 0 || q32.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain", q16.size() + q32.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [13:0] trace;
        logic [15:0] stallA[4];
        res_t        exp0;
        int          base;
        int          seen;

        rst_n = 1'b0;
        inValid16 = 1'b0; outReady16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        inValid32 = 1'b0; outReady32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;

        outReady16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid16", outValid16, 0);
        checkOutput("reset sum16", sum16, 0);
        checkOutput("reset cout16", cout16, 0);
        checkOutput("reset ovf16", ovf16, 0);
        checkOutput("reset in_ready16", inReady16, 1);
        checkOutput("reset out_valid32", outValid32, 0);
        checkOutput("reset sum32", sum32, 0);
        outReady16 = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runOne(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        runOne(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub");
        runOne(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf");
        waitIdle();

        for (int j = 0; j < 14; j++) begin
            if (j < 8) applyStimulus(16'h1111 + 16'(j), 16'h1111, 1'b0, 1'b0);
            else       inValid16 = 1'b0;
            @(posedge clk);
            #1;
            trace[j] = outValid16;
        end
        checkOutput("b2b out_valid trace", trace, 14'b00_0111_1111_1000);
        waitIdle();

        base = outCount16;
        for (int j = 0; j < 4; j++) begin
            stallA[j] = 16'h1000 * 16'(j) + 16'h0321;
            applyStimulus(stallA[j], 16'h0F0F, 1'b1, 1'(j));
            @(posedge clk);
            #1;
        end
        inValid16 = 1'b0;
        exp0 = refModel(16, {16'h0, stallA[0]}, 32'h0F0F, 1'b1, 1'b0);
        outReady16 = 1'b0;
        #1;
        checkOutput("stall in_ready", inReady16, 0);
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            checkOutput("stall in_ready hold", inReady16, 0);
            checkOutput("stall out_valid hold", outValid16, 1);
            checkOutput("stall sum hold", sum16, exp0.sum[15:0]);
        end
        outReady16 = 1'b1;
        waitIdle();
        checkOutput("stall drained count", outCount16 - base, 4);

        for (int j = 0; j < 3; j++) begin
            applyStimulus(16'h2222 + 16'(j), 16'h0101, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        inValid16 = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", outValid16, 0);
        checkOutput("midreset in_ready", inReady16, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int s = 0; s < 8; s++) begin
            @(posedge clk);
            #1;
            if (outValid16) seen++;
        end
        checkOutput("no output after reset", seen, 0);
        runOne(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "post-reset");
        waitIdle();

        for (int c = 0; c < 400; c++) begin
            inValid32  = ($urandom_range(0, 3) != 0);
            outReady32 = ($urandom_range(0, 3) != 0);
            a32   = pickOperand();
            b32   = pickOperand();
            cin32 = 1'($urandom_range(0, 1));
            sub32 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        inValid32 = 1'b0;
        outReady32 = 1'b1;
        waitIdle();
        checkOutput("sweep32 accept vs output count", outCount32, acceptCount32);

        a32 = 32'h0000_0001;
        b32 = 32'hFFFF_FFFF;
        cin32 = 1'b0;
        sub32 = 1'b0;
        inValid32 = 1'b1;
        @(posedge clk);
        #1;
        inValid32 = 1'b0;
        seen = 0;
        while (!outValid32 && seen < 20) begin
            @(posedge clk);
            #1;
            seen++;
        end
        checkOutput("zero32 case out_valid", outValid32, 1);
        checkOutput("zero32 case sum", sum32, 32'h0);
        checkOutput("zero32 case cout", cout32, 1);
`ifdef CLA_FLAGS_EN
        checkOutput("zero32 case zero flag", zero32, 1);
        checkOutput("zero32 case neg flag", neg32, 0);
`endif
        waitIdle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
